// File: rtl/crc_ahb_feeder.sv
// crc_ahb_feeder: AHB-Lite initiator that programs CRC_CR, streams words into CRC_DR and
// reads the result back. Define CRC_FEEDER_INIT_WR_EN to add a CRC_INIT write (cmd_init port).
module crc_ahb_feeder #(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_base,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       cmd_ctrl,
`ifdef CRC_FEEDER_INIT_WR_EN
    input  logic [31:0]      cmd_init,
`endif
    input  logic             src_valid,
    input  logic [31:0]      src_data,
    output logic             src_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_error
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [4:0] OffDr       = 5'h00;
    localparam logic [4:0] OffCr       = 5'h08;
    localparam logic [4:0] OffInit     = 5'h10;
    localparam int unsigned WaitW      = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StCr,
        StData,
        StRd,
        StRdd,
        StRes
    } state_e;

    state_e             state_q, state_d;
    logic [26:0]        base_q, base_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         ctrl_q, ctrl_d;
    logic [31:0]        hwdata_q, hwdata_d;
    logic               dp_valid_q, dp_valid_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [31:0]        res_data_q, res_data_d;
    logic               res_error_q, res_error_d;
`ifdef CRC_FEEDER_INIT_WR_EN
    logic [31:0]        init_q, init_d;
`endif

    logic               issue;
    logic               hwrite;
    logic [4:0]         off;
    logic [31:0]        wr_data;
    logic               timeout;
    logic               abort;
    logic               unused_base;

    // Base is 32-byte aligned; the low address bits come from the register offset.
    assign unused_base = ^cmd_base[4:0];

    assign timeout = dp_valid_q && !HREADY && (wait_q == WaitW'(TIMEOUT - 1));
    assign abort   = dp_valid_q && (HRESP || timeout);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        hwdata_d    = hwdata_q;
        dp_valid_d  = dp_valid_q;
        wait_d      = '0;
        res_data_d  = res_data_q;
        res_error_d = res_error_q;
`ifdef CRC_FEEDER_INIT_WR_EN
        init_d      = init_q;
`endif
        issue       = 1'b0;
        hwrite      = 1'b0;
        off         = OffDr;
        wr_data     = hwdata_q;
        cmd_ready   = 1'b0;
        src_ready   = 1'b0;
        res_valid   = 1'b0;

        if (dp_valid_q && !HREADY) begin
            wait_d = wait_q + WaitW'(1);
        end

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    base_d      = cmd_base[31:5];
                    cnt_d       = cmd_len;
                    ctrl_d      = cmd_ctrl;
                    res_data_d  = '0;
                    res_error_d = 1'b0;
`ifdef CRC_FEEDER_INIT_WR_EN
                    init_d      = cmd_init;
                    state_d     = StInit;
`else
                    state_d     = StCr;
`endif
                end
            end
            StInit: begin
                issue   = 1'b1;
                hwrite  = 1'b1;
                off     = OffInit;
`ifdef CRC_FEEDER_INIT_WR_EN
                wr_data = init_q;
`endif
                if (HREADY) begin
                    state_d = StCr;
                end
            end
            StCr: begin
                issue   = 1'b1;
                hwrite  = 1'b1;
                off     = OffCr;
                wr_data = {24'h0, ctrl_q};
                if (HREADY) begin
                    state_d = (cnt_q == '0) ? StRd : StData;
                end
            end
            StData: begin
                // Only offer a transfer when the source has a word to hand over.
                issue   = src_valid;
                hwrite  = 1'b1;
                wr_data = src_data;
                if (HREADY && src_valid) begin
                    src_ready = 1'b1;
                    cnt_d     = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                issue = 1'b1;
                if (HREADY) begin
                    state_d = StRdd;
                end
            end
            StRdd: begin
                if (HREADY) begin
                    res_data_d = HRDATA;
                    state_d    = StRes;
                end
            end
            StRes: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Error or timeout: withdraw any pipelined address phase and report.
        if (abort) begin
            issue       = 1'b0;
            src_ready   = 1'b0;
            cnt_d       = cnt_q;
            state_d     = StRes;
            res_data_d  = '0;
            res_error_d = 1'b1;
            dp_valid_d  = 1'b0;
            wait_d      = '0;
        end else if (HREADY) begin
            dp_valid_d = issue;
            if (issue && hwrite) begin
                hwdata_d = wr_data;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            base_q      <= '0;
            cnt_q       <= '0;
            ctrl_q      <= '0;
            hwdata_q    <= '0;
            dp_valid_q  <= 1'b0;
            wait_q      <= '0;
            res_data_q  <= '0;
            res_error_q <= 1'b0;
`ifdef CRC_FEEDER_INIT_WR_EN
            init_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            hwdata_q    <= hwdata_d;
            dp_valid_q  <= dp_valid_d;
            wait_q      <= wait_d;
            res_data_q  <= res_data_d;
            res_error_q <= res_error_d;
`ifdef CRC_FEEDER_INIT_WR_EN
            init_q      <= init_d;
`endif
        end
    end

    assign HTRANS    = issue ? TransNonseq : TransIdle;
    assign HADDR     = issue ? {base_q, off} : 32'h0;
    assign HWRITE    = issue && hwrite;
    assign HSIZE     = 3'b010;
    assign HWDATA    = hwdata_q;
    assign res_data  = res_data_q;
    assign res_error = res_error_q;

endmodule

// File: tb/tb_crc_ahb_feeder.sv
// Bench for crc_ahb_feeder: scripted AHB slave (waits/errors), word source, and queue
// scoreboards for address phases, write data and results.
`timescale 1ns/1ps
module tb_crc_ahb_feeder;
`ifdef CRC_FEEDER_INIT_WR_EN
    localparam int PRE = 1;
`else
    localparam int PRE = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE, HREADY, HRESP;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_base = '0, cmd_init = '0;
    logic [15:0] cmd_len = '0;
    logic [7:0]  cmd_ctrl = '0;
    logic        src_valid, src_ready;
    logic [31:0] src_data;
    logic        res_valid, res_error;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;

    crc_ahb_feeder dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .cmd_ctrl  (cmd_ctrl),
`ifdef CRC_FEEDER_INIT_WR_EN
        .cmd_init  (cmd_init),
`endif
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_error (res_error)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard queues: {write, addr}, write data, {error, data}.
    logic [32:0] addr_q[$];
    logic [31:0] wd_q[$];
    logic [32:0] res_q[$];

    // Slave model knobs (transfer index counted from command acceptance).
    int          stall_idx = -1, stall_len = 0, err_idx = -1;
    logic [31:0] rd_val = '0;
    int          s_idx = 0, s_wait = 0, s_this = 0;
    bit          s_err = 1'b0;
    logic        n_rdy, n_resp;

    initial begin
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        forever begin
            @(negedge HCLK);
            n_rdy = 1'b1; n_resp = 1'b0;
            if (!HRESETn) begin
                s_idx = 0; s_wait = 0; s_err = 1'b0;
            end else begin
                if (cmd_valid && cmd_ready) s_idx = 0;
                if (HREADY) begin
                    if (HTRANS == 2'b10) begin
                        s_this = s_idx;
                        s_idx++;
                        if (s_this == err_idx) begin
                            n_rdy = 1'b0; n_resp = 1'b1; s_err = 1'b1;
                        end else if (s_this == stall_idx) begin
                            n_rdy = 1'b0; s_wait = stall_len - 1;
                        end
                    end
                end else if (s_err) begin
                    n_rdy = 1'b1; n_resp = 1'b1; s_err = 1'b0;
                end else if (s_wait > 0) begin
                    n_rdy = 1'b0; s_wait--;
                end
            end
            @(posedge HCLK); #1;
            HREADY = n_rdy; HRESP = n_resp; HRDATA = rd_val;
        end
    end

    // Word source.
    logic [31:0] src_words[$];
    bit          src_en = 1'b0, src_avail = 1'b0, took;
    int          src_cnt = 0;
    assign src_valid = src_en && src_avail;

    initial begin
        src_data = '0;
        forever begin
            @(negedge HCLK);
            took = src_valid && src_ready && HRESETn;
            @(posedge HCLK); #1;
            if (took) begin
                void'(src_words.pop_front());
                src_cnt++;
            end
            src_avail = (src_words.size() > 0);
            src_data  = src_avail ? src_words[0] : 32'h0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents something.
    bit          hold_chk = 1'b0;
    bit          dp_v = 1'b0, dp_w = 1'b0, p_rdy = 1'b1, p_resp = 1'b0;
    logic [1:0]  p_trans = '0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    int          res_seen = 0;

    initial forever begin
        @(negedge HCLK);
        if (!HRESETn) begin
            dp_v = 1'b0; p_rdy = 1'b1; p_resp = 1'b0;
        end else begin
            if (dp_v && HRESP) check("cancel_on_error", {31'h0, HTRANS}, 33'h0);
            if (hold_chk && !p_rdy && !HRESP && !p_resp && p_trans == 2'b10) begin
                check("hold_haddr", {1'b0, HADDR}, {1'b0, p_addr});
                check("hold_hwdata", {1'b0, HWDATA}, {1'b0, p_wdata});
                check("hold_htrans", {31'h0, HTRANS}, {31'h0, p_trans});
            end
            if (dp_v && dp_w && HREADY && !HRESP) begin
                if (wd_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL wdata_unexpected: got %0h, none expected", HWDATA);
                end else begin
                    check("hwdata", {1'b0, HWDATA}, {1'b0, wd_q.pop_front()});
                end
            end
            if (HREADY) begin
                if (HTRANS == 2'b10) begin
                    if (addr_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL addr_unexpected: got %0h, none expected", HADDR);
                    end else begin
                        check("addr_phase", {HWRITE, HADDR}, addr_q.pop_front());
                    end
                    check("hsize", {30'h0, HSIZE}, 33'h2);
                    dp_v = 1'b1; dp_w = HWRITE;
                end else begin
                    dp_v = 1'b0;
                end
            end
            if (res_valid && res_ready) begin
                if (res_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL res_unexpected: got %0h, none expected", res_data);
                end else begin
                    check("result", {res_error, res_data}, res_q.pop_front());
                end
                res_seen++;
            end
            p_rdy = HREADY; p_resp = HRESP; p_trans = HTRANS;
            p_addr = HADDR; p_wdata = HWDATA;
        end
    end

    // Expectation helpers.
    function automatic logic [31:0] al(input logic [31:0] b);
        return b & 32'hFFFF_FFE0;
    endfunction

    task automatic push_hdr(input logic [31:0] b, input logic [7:0] ctrl, input logic [31:0] init,
                            input bit cr_done);
`ifdef CRC_FEEDER_INIT_WR_EN
        addr_q.push_back({1'b1, al(b) | 32'h10});
        wd_q.push_back(init);
`endif
        addr_q.push_back({1'b1, al(b) | 32'h08});
        if (cr_done) wd_q.push_back({24'h0, ctrl});
    endtask

    task automatic push_word(input logic [31:0] b, input logic [31:0] w, input bit acc,
                             input bit done);
        src_words.push_back(w);
        if (acc) addr_q.push_back({1'b1, al(b)});
        if (done) wd_q.push_back(w);
    endtask

    task automatic issue(input logic [31:0] b, input logic [7:0] ctrl, input logic [15:0] len,
                         input logic [31:0] init);
        bit ok;
        ok = 1'b0;
        @(posedge HCLK); #1;
        cmd_base = b; cmd_ctrl = ctrl; cmd_len = len; cmd_init = init; cmd_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge HCLK);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_handshake", {32'h0, ok}, 33'h1);
        hs_cyc = cyc;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output int n);
        n = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge HCLK);
            if (res_valid) begin
                n = cyc - hs_cyc;
                break;
            end
        end
        if (n < 0) begin
            n_checks++; n_errors++;
            $display("FAIL res_timeout: got no res_valid, required one within 1000 cycles");
        end
    endtask

    int          n, s0;
    logic [31:0] b;
    logic [4:0]  pat;

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        check("rst_htrans", {31'h0, HTRANS}, 33'h0);
        check("rst_haddr", {1'b0, HADDR}, 33'h0);
        check("rst_hwrite", {32'h0, HWRITE}, 33'h0);
        check("rst_hwdata", {1'b0, HWDATA}, 33'h0);
        check("rst_cmd_ready", {32'h0, cmd_ready}, 33'h1);
        check("rst_src_ready", {32'h0, src_ready}, 33'h0);
        check("rst_res", {res_valid, res_error, res_data[30:0]}, 33'h0);

        // Back-to-back stream, no waits.
        b = 32'h4000_0000; rd_val = 32'hCBF4_3926;
        push_hdr(b, 8'h01, 32'hFFFF_FFFF, 1'b1);
        push_word(b, 32'h1111_0001, 1'b1, 1'b1);
        push_word(b, 32'h2222_0002, 1'b1, 1'b1);
        push_word(b, 32'h3333_0003, 1'b1, 1'b1);
        addr_q.push_back({1'b0, b});
        res_q.push_back({1'b0, 32'hCBF4_3926});
        s0 = src_cnt; src_en = 1'b1;
        issue(b, 8'h01, 16'd3, 32'hFFFF_FFFF);
        wait_res(n);
        check("lat_len3", 33'(n), 33'(7 + PRE));
        repeat (2) @(negedge HCLK);
        check("src_cnt_len3", 33'(src_cnt - s0), 33'd3);

        // Four wait states on the 2nd data phase; unaligned base must be masked.
        b = 32'h4000_1233; rd_val = 32'h0BAD_F00D; stall_idx = PRE + 2; stall_len = 4;
        push_hdr(b, 8'h01, 32'h0, 1'b1);
        push_word(b, 32'hA0A0_0001, 1'b1, 1'b1);
        push_word(b, 32'hB0B0_0002, 1'b1, 1'b1);
        push_word(b, 32'hC0C0_0003, 1'b1, 1'b1);
        addr_q.push_back({1'b0, 32'h4000_1220});
        res_q.push_back({1'b0, 32'h0BAD_F00D});
        s0 = src_cnt; hold_chk = 1'b1;
        issue(b, 8'h01, 16'd3, 32'h0);
        wait_res(n);
        hold_chk = 1'b0; stall_idx = -1;
        check("lat_stall", 33'(n), 33'(11 + PRE));
        repeat (2) @(negedge HCLK);
        check("src_cnt_stall", 33'(src_cnt - s0), 33'd3);

        // len=0: only CR write and DR read; result held while res_ready low.
        b = 32'h5000_0000; rd_val = 32'h1234_5678; res_ready = 1'b0;
        push_hdr(b, 8'h00, 32'h5555_AAAA, 1'b1);
        addr_q.push_back({1'b0, b});
        res_q.push_back({1'b0, 32'h1234_5678});
        issue(b, 8'h00, 16'd0, 32'h5555_AAAA);
        wait_res(n);
        check("lat_len0", 33'(n), 33'(4 + PRE));
        rd_val = 32'hDEAD_0000;
        repeat (3) @(negedge HCLK);
        check("res_held_valid", {32'h0, res_valid}, 33'h1);
        check("res_held_data", {1'b0, res_data}, {1'b0, 32'h1234_5678});
        @(posedge HCLK); #1 res_ready = 1'b1;
        repeat (2) @(negedge HCLK);

        // src_valid toggling: IDLE cycles between words, order preserved.
        b = 32'h4000_0000; rd_val = 32'h7777_0004; src_en = 1'b0;
        push_hdr(b, 8'h01, 32'h0, 1'b1);
        push_word(b, 32'h0000_00A1, 1'b1, 1'b1);
        push_word(b, 32'h0000_00B2, 1'b1, 1'b1);
        push_word(b, 32'h0000_00C3, 1'b1, 1'b1);
        addr_q.push_back({1'b0, b});
        res_q.push_back({1'b0, 32'h7777_0004});
        issue(b, 8'h01, 16'd3, 32'h0);
        repeat (1 + PRE) @(posedge HCLK);
        #1;
        pat = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            src_en = pat[4 - i];
            @(negedge HCLK);
            if (i < 4) check("toggle_htrans", {31'h0, HTRANS}, pat[4 - i] ? 33'h2 : 33'h0);
            @(posedge HCLK); #1;
        end
        src_en = 1'b1;
        wait_res(n);
        check("lat_toggle", 33'(n), 33'(9 + PRE));
        repeat (2) @(negedge HCLK);

        // ERROR response on the 2nd data write.
        b = 32'h4000_0000; rd_val = 32'hFACE_FACE; err_idx = PRE + 2;
        push_hdr(b, 8'h01, 32'h0, 1'b1);
        push_word(b, 32'hE000_0001, 1'b1, 1'b1);
        push_word(b, 32'hE000_0002, 1'b1, 1'b0);
        push_word(b, 32'hE000_0003, 1'b0, 1'b0);
        res_q.push_back({1'b1, 32'h0});
        s0 = src_cnt;
        issue(b, 8'h01, 16'd3, 32'h0);
        wait_res(n);
        err_idx = -1;
        check("lat_error", 33'(n), 33'(5 + PRE));
        repeat (2) @(negedge HCLK);
        check("src_cnt_error", 33'(src_cnt - s0), 33'd2);
        check("src_left_error", 33'(src_words.size()), 33'd1);
        src_en = 1'b0;
        src_words.delete();

        // HREADY stuck low on the 1st data phase: abort after TIMEOUT cycles.
        stall_idx = PRE + 1; stall_len = 300; src_en = 1'b1;
        push_hdr(b, 8'h01, 32'h0, 1'b1);
        push_word(b, 32'hD000_0001, 1'b1, 1'b0);
        push_word(b, 32'hD000_0002, 1'b0, 1'b0);
        res_q.push_back({1'b1, 32'h0});
        issue(b, 8'h01, 16'd2, 32'h0);
        wait_res(n);
        check("lat_timeout", 33'(n), 33'(259 + PRE));
        @(posedge HCLK); #1;
        HRESETn = 1'b0; stall_idx = -1; src_en = 1'b0;
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        src_words.delete();

        // Reset while a data word is being offered under wait states.
        stall_idx = PRE; stall_len = 50; src_en = 1'b1;
        push_hdr(b, 8'h01, 32'h0, 1'b0);
        push_word(b, 32'h9999_0001, 1'b0, 1'b0);
        s0 = src_cnt;
        issue(b, 8'h01, 16'd2, 32'h0);
        repeat (3) @(negedge HCLK);
        check("stalled_nonseq", {31'h0, HTRANS}, 33'h2);
        @(posedge HCLK); #1 HRESETn = 1'b0; stall_idx = -1;
        @(posedge HCLK);
        @(negedge HCLK);
        check("rstmid_htrans", {31'h0, HTRANS}, 33'h0);
        check("rstmid_haddr", {1'b0, HADDR}, 33'h0);
        check("rstmid_cmd_ready", {32'h0, cmd_ready}, 33'h1);
        check("rstmid_src_ready", {32'h0, src_ready}, 33'h0);
        check("rstmid_res_valid", {32'h0, res_valid}, 33'h0);
        @(posedge HCLK); #1 HRESETn = 1'b1; src_en = 1'b0;
        check("src_cnt_rstmid", 33'(src_cnt - s0), 33'd0);
        src_words.delete();
        repeat (2) @(negedge HCLK);

        // Normal command after the reset.
        b = 32'h6000_0040; rd_val = 32'h0F0F_1234; src_en = 1'b1;
        push_hdr(b, 8'h03, 32'h1357_9BDF, 1'b1);
        push_word(b, 32'h4242_4242, 1'b1, 1'b1);
        addr_q.push_back({1'b0, b});
        res_q.push_back({1'b0, 32'h0F0F_1234});
        issue(b, 8'h03, 16'd1, 32'h1357_9BDF);
        wait_res(n);
        check("lat_len1", 33'(n), 33'(5 + PRE));
        repeat (3) @(negedge HCLK);

        check("addr_q_empty", 33'(addr_q.size()), 33'd0);
        check("wd_q_empty", 33'(wd_q.size()), 33'd0);
        check("res_q_empty", 33'(res_q.size()), 33'd0);
        check("res_count", 33'(res_seen), 33'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
